// File: rtl/sub32_pipe_pkg.sv
// Shared widths and carry-lookahead helpers for the two-stage subtractor.
// Only 4-bit lookahead groups are supported by these helpers.
package sub32_pipe_pkg;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned HALF  = 16;
    localparam int unsigned GROUP = 4;
    localparam int unsigned NGRP  = HALF / GROUP;

    // Carries into bits 1..3 of a 4-bit group, given its carry-in.
    function automatic logic [2:0] cla_carry3(input logic [2:0] g, input logic [2:0] p,
                                              input logic cin);
        logic [2:0] c;
        c[0] = g[0] | (p[0] & cin);
        c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
        return c;
    endfunction

    function automatic logic cla_gen4(input logic [3:0] g, input logic [3:0] p);
        return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    endfunction

    function automatic logic cla_prop4(input logic [3:0] p);
        return &p;
    endfunction

endpackage

// File: rtl/sub32_pipe_cla16.sv
// 16-bit two-level carry-lookahead adder: four 4-bit groups plus a group-level
// lookahead unit, so no carry ripples through more than one level of groups.
module sub32_pipe_cla16
    import sub32_pipe_pkg::*;
(
    input  logic [HALF-1:0] a,
    input  logic [HALF-1:0] b,
    input  logic            cin,
    output logic [HALF-1:0] sum,
    output logic            cout
);

    logic [HALF-1:0] g;
    logic [HALF-1:0] p;
    logic [HALF-1:0] c;
    logic [NGRP-1:0] grp_g;
    logic [NGRP-1:0] grp_p;
    logic [NGRP-1:0] grp_cin;
    logic [2:0]      top_c;

    assign g = a & b;
    assign p = a ^ b;

    for (genvar k = 0; k < NGRP; k++) begin : g_grp
        logic [2:0] loc_c;

        assign grp_g[k] = cla_gen4(g[k*GROUP +: GROUP], p[k*GROUP +: GROUP]);
        assign grp_p[k] = cla_prop4(p[k*GROUP +: GROUP]);
        assign loc_c    = cla_carry3(g[k*GROUP +: 3], p[k*GROUP +: 3], grp_cin[k]);
        assign c[k*GROUP +: GROUP] = {loc_c, grp_cin[k]};
    end

    // Second lookahead level works on group generate/propagate.
    assign top_c   = cla_carry3(grp_g[2:0], grp_p[2:0], cin);
    assign grp_cin = {top_c, cin};
    assign cout    = cla_gen4(grp_g, grp_p) | (cla_prop4(grp_p) & cin);

    assign sum = p ^ c;

endmodule

// File: rtl/sub32_pipe.sv
// Two-stage pipelined 32-bit subtractor, a - b = a + ~b + 1, low half in stage 1 and
// high half in stage 2, with valid/ready handshakes and borrow/overflow/zero flags.
module sub32_pipe
    import sub32_pipe_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             overflow,
    output logic             zero
);

    logic            s1_valid;
    logic [HALF-1:0] s1_diff_lo;
    logic            c16_r;
    logic [HALF-1:0] a_hi_r;
    logic [HALF-1:0] b_hi_r;

    logic [HALF-1:0] lo_sum;
    logic            lo_cout;
    logic [HALF-1:0] hi_sum;
    logic            c32;
    logic [HALF-1:0] b_lo_n;
    logic [HALF-1:0] b_hi_n;

    logic s2_free;
    logic s1_free;
    logic accept;
    logic transfer;

    assign s2_free  = !out_valid || out_ready;
    assign s1_free  = !s1_valid || s2_free;
    assign in_ready = s1_free;
    assign accept   = in_valid && in_ready;
    assign transfer = s1_valid && s2_free;

    assign b_lo_n = ~b[HALF-1:0];
    assign b_hi_n = ~b_hi_r;

    sub32_pipe_cla16 u_cla_lo (
        .a    (a[HALF-1:0]),
        .b    (b_lo_n),
        .cin  (1'b1),
        .sum  (lo_sum),
        .cout (lo_cout)
    );

    sub32_pipe_cla16 u_cla_hi (
        .a    (a_hi_r),
        .b    (b_hi_n),
        .cin  (c16_r),
        .sum  (hi_sum),
        .cout (c32)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid   <= 1'b0;
            s1_diff_lo <= '0;
            c16_r      <= 1'b0;
            a_hi_r     <= '0;
            b_hi_r     <= '0;
        end else if (accept) begin
            s1_valid   <= 1'b1;
            s1_diff_lo <= lo_sum;
            c16_r      <= lo_cout;
            a_hi_r     <= a[WIDTH-1:HALF];
            b_hi_r     <= b[WIDTH-1:HALF];
        end else if (transfer) begin
            s1_valid <= 1'b0;
        end
    end

    // Signed overflow: operand signs differ and the result sign departs from a.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            diff      <= '0;
            borrow    <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
        end else if (transfer) begin
            out_valid <= 1'b1;
            diff      <= {hi_sum, s1_diff_lo};
            borrow    <= ~c32;
            overflow  <= (a_hi_r[HALF-1] != b_hi_r[HALF-1]) && (hi_sum[HALF-1] != a_hi_r[HALF-1]);
            zero      <= ({hi_sum, s1_diff_lo} == '0);
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sub32_pipe.sv
// Bench for sub32_pipe: directed vectors with literal expectations plus a queue model
// of a - b checked on every output handshake, stall stability and reset discard.
module tb_sub32_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] diff;
    logic        borrow;
    logic        overflow;
    logic        zero;

    sub32_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .borrow    (borrow),
        .overflow  (overflow),
        .zero      (zero)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
    } op_t;

    op_t         mq[$];
    int          pop_cyc[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          pops = 0;
    logic        stall_prev = 1'b0;
    logic        saw_inready_low = 1'b0;
    logic [31:0] prev_diff;
    logic [2:0]  prev_flags;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: sample the handshakes at negedge, compute results with plain arithmetic.
    always @(negedge clk) begin
        if (!rst_n) begin
            mq.delete();
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("stall_valid", 32'(out_valid), 32'd1);
                chk("stall_diff", diff, prev_diff);
                chk("stall_flags", 32'({borrow, overflow, zero}), 32'(prev_flags));
            end
            if (in_valid && !in_ready) saw_inready_low = 1'b1;
            if (out_valid && out_ready) begin
                if (mq.size() == 0) begin
                    chk("unexpected_result", 32'd0, 32'd1);
                end else begin
                    op_t    op;
                    longint sd;
                    logic [31:0] ed;
                    op = mq.pop_front();
                    ed = op.a - op.b;
                    sd = longint'($signed(op.a)) - longint'($signed(op.b));
                    chk("model_diff", diff, ed);
                    chk("model_borrow", 32'(borrow), 32'(op.a < op.b));
                    chk("model_overflow", 32'(overflow),
                        32'(sd > 64'sd2147483647 || sd < -64'sd2147483648));
                    chk("model_zero", 32'(zero), 32'(ed == 32'd0));
                end
                pops++;
                pop_cyc.push_back(cyc);
            end
            if (in_valid && in_ready) mq.push_back('{a: a, b: b});
            stall_prev = out_valid && !out_ready;
            prev_diff  = diff;
            prev_flags = {borrow, overflow, zero};
        end
    end

    // Present one operand pair and hold it until accepted; returns at posedge + 1.
    task automatic push_op(input logic [31:0] av, input logic [31:0] bv);
        int n;
        a = av;
        b = bv;
        in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic single_op(input logic [31:0] av, input logic [31:0] bv,
                             input logic [31:0] ed, input logic eb, input logic eo,
                             input logic ez);
        int acc;
        int n;
        @(posedge clk);
        #1;
        a = av;
        b = bv;
        in_valid = 1'b1;
        @(negedge clk);
        chk("single_in_ready", 32'(in_ready), 32'd1);
        acc = cyc;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("latency", 32'(cyc - acc), 32'd2);
        chk("lit_diff", diff, ed);
        chk("lit_borrow", 32'(borrow), 32'(eb));
        chk("lit_overflow", 32'(overflow), 32'(eo));
        chk("lit_zero", 32'(zero), 32'(ez));
    endtask

    task automatic drain();
        int n;
        n = 0;
        @(negedge clk);
        while ((out_valid || mq.size() != 0) && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("drain_empty", 32'(mq.size()), 32'd0);
    endtask

    task automatic run_stream(input int stall_at);
        logic [31:0] sa[8];
        logic [31:0] sb[8];
        sa = '{32'h0000_0010, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0001_0000,
               32'h1234_5678, 32'h7FFF_FFFF, 32'h0000_0000, 32'hDEAD_BEEF};
        sb = '{32'h0000_0001, 32'h0000_0001, 32'h7FFF_FFFF, 32'h0000_FFFF,
               32'h1234_5678, 32'h8000_0000, 32'h0000_0001, 32'h0BAD_F00D};
        pops = 0;
        pop_cyc.delete();
        saw_inready_low = 1'b0;
        @(posedge clk);
        #1;
        fork
            begin
                for (int i = 0; i < 8; i++) push_op(sa[i], sb[i]);
            end
            begin
                if (stall_at > 0) begin
                    repeat (stall_at) @(posedge clk);
                    #1;
                    out_ready = 1'b0;
                    repeat (3) @(posedge clk);
                    #1;
                    out_ready = 1'b1;
                end
            end
        join
        drain();
        chk("stream_count", 32'(pops), 32'd8);
        chk("stream_inready_low", 32'(saw_inready_low), 32'(stall_at > 0));
        if (stall_at == 0 && pop_cyc.size() == 8)
            chk("stream_back_to_back", 32'(pop_cyc[7] - pop_cyc[0]), 32'd7);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        a = '0;
        b = '0;
        #22;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_diff", diff, 32'd0);
        chk("reset_flags", 32'({borrow, overflow, zero}), 32'd0);
        rst_n = 1'b1;

        single_op(32'd5, 32'd3, 32'h0000_0002, 1'b0, 1'b0, 1'b0);
        single_op(32'd3, 32'd5, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0);
        single_op(32'h0001_0000, 32'd1, 32'h0000_FFFF, 1'b0, 1'b0, 1'b0);
        single_op(32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
        single_op(32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 1'b0, 1'b0, 1'b1);
        single_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 1'b1, 1'b0);
        drain();

        run_stream(0);
        run_stream(4);

        // Fill both stages under backpressure, then reset mid-flight.
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        push_op(32'd100, 32'd1);
        push_op(32'd200, 32'd2);
        a = 32'd300;
        b = 32'd3;
        in_valid = 1'b1;
        @(negedge clk);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("full_out_valid", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_out_valid", 32'(out_valid), 32'd0);
        chk("async_in_ready", 32'(in_ready), 32'd1);
        chk("async_diff", diff, 32'd0);
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        single_op(32'hA000_0000, 32'h2000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
